cpu_run_ctrl: RTL and testbench

Run/step/breakpoint sequencer for the single-cycle RISC-V core on the FPGA board. It replaces the divided-clock scheme: the core and dmem_io run on the board clock `clk`, gated by a one-cycle clock-enable `cpu_ce` that this block issues. It provides free-run, halt, button single-step and PC breakpoint modes, plus a stretched synchronous CPU reset. It sits between the board buttons/switches and the core; `pc` is fed back from the core.

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/cpu_run_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  localparam int DEF_CE_PERIOD       = 10_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_RESET_CE        = 2;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, accepted level
// and a one-cycle pulse on the accepted rising edge.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          synced;

  assign synced = sync_ff[1];

  // The accepted level flips on the edge that ends the Nth consecutive
  // differing cycle; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn};
      rise    <= 1'b0;
      if (synced != level) begin
        if (cnt == CMAX) begin
          level <= synced;
          rise  <= synced;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer issuing a one-cycle clock enable to the core.
// cpu_ce is the only combinational output; everything else is registered.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CE_PERIOD       = DEF_CE_PERIOD,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_CE        = DEF_RESET_CE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        rst_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_ce,
  output logic        cpu_reset,
  output logic        halted,
  output logic        bp_hit,
  output logic [1:0]  state,
  output logic [31:0] instr_count
);

  localparam int PW = $clog2(CE_PERIOD);
  localparam logic [PW-1:0] PMAX = PW'(CE_PERIOD - 1);
  localparam int RW = $clog2(RESET_CE + 1);
  localparam logic [RW-1:0] RMAX = RW'(RESET_CE - 1);

  state_t        cur, nxt;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] rcnt;
  logic [1:0]    run_ff;
  logic          run_d, run_s, run_rise;
  logic          step_evt, step_level_unused;
  logic          rst_level, rst_rise;
  logic          tick, bp_match, bp_stop, skip;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst_n(reset_n), .btn(step_btn),
    .level(step_level_unused), .rise(step_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk(clk), .rst_n(reset_n), .btn(rst_btn),
    .level(rst_level), .rise(rst_rise)
  );

  assign run_s    = run_ff[1];
  assign run_rise = run_s & ~run_d;
  assign tick     = (pcnt == PMAX);
  assign bp_match = bp_en && (pc == bp_addr);
  assign state    = cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= ST_RESET;
    else          cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_RESET: if (tick && rcnt == RMAX && !rst_level) nxt = run_s ? ST_RUN : ST_HALT;
      ST_RUN: begin
        if (!run_s)                          nxt = ST_HALT;
        else if (tick && bp_match && !skip)  nxt = ST_HALT;
      end
      ST_HALT: begin
        if (run_rise)      nxt = ST_RUN;
        else if (step_evt) nxt = ST_STEP;
      end
      ST_STEP: nxt = ST_HALT;
      default: nxt = ST_RESET;
    endcase
    if (rst_rise) nxt = ST_RESET;
  end

  // An enable already decided for this cycle stands even if a reset request
  // lands at the same time.
  always_comb begin
    cpu_ce  = 1'b0;
    bp_stop = 1'b0;
    case (cur)
      ST_RESET: cpu_ce = tick;
      ST_RUN: begin
        if (run_s && tick) begin
          if (bp_match && !skip) bp_stop = 1'b1;
          else                   cpu_ce  = 1'b1;
        end
      end
      ST_STEP: cpu_ce = 1'b1;
      default: cpu_ce = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_ff      <= 2'b00;
      run_d       <= 1'b0;
      pcnt        <= '0;
      rcnt        <= '0;
      skip        <= 1'b0;
      bp_hit      <= 1'b0;
      instr_count <= '0;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
    end else begin
      run_ff <= {run_ff[0], run_sw};
      run_d  <= run_s;

      if (nxt != cur || tick) pcnt <= '0;
      else                    pcnt <= pcnt + PW'(1);

      if (cur != ST_RESET || rst_level) rcnt <= '0;
      else if (tick)                    rcnt <= rcnt + RW'(1);

      // skip lets the first instruction after a resume leave the breakpoint PC.
      if (cur == ST_HALT && (nxt == ST_RUN || nxt == ST_STEP)) skip <= 1'b1;
      else if (cpu_ce || cur == ST_RESET)                      skip <= 1'b0;

      if (nxt == ST_RESET)                     bp_hit <= 1'b0;
      else if (bp_stop)                        bp_hit <= 1'b1;
      else if (cur == ST_HALT && nxt != ST_HALT) bp_hit <= 1'b0;

      if (nxt == ST_RESET)                  instr_count <= '0;
      else if (cpu_ce && cur != ST_RESET)   instr_count <= instr_count + 32'd1;

      cpu_reset <= (nxt == ST_RESET);
      halted    <= (nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: each expected cpu_ce pulse is queued and a
// monitor pops and compares it whenever the DUT raises cpu_ce.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset_n;
  logic        run_sw, step_btn, rst_btn, bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_ce, cpu_reset, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] instr_count;
  logic        pc_set;
  logic [31:0] pc_set_val;

  int checks   = 0;
  int failures = 0;

  // {state, cpu_reset, instr_count, pc} seen on a cpu_ce cycle
  logic [66:0] exp_q[$];

  localparam logic [1:0] S_RESET = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_STEP = 2'd3;

  cpu_run_ctrl #(.CE_PERIOD(4), .DEBOUNCE_CYCLES(3), .RESET_CE(2)) dut (
    .clk(clk), .reset_n(reset_n), .run_sw(run_sw), .step_btn(step_btn),
    .rst_btn(rst_btn), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .halted(halted), .bp_hit(bp_hit),
    .state(state), .instr_count(instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PC advances by 4 on each enable, cleared by an enabled reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pc <= 32'd0;
    else if (pc_set)  pc <= pc_set_val;
    else if (cpu_ce)  pc <= cpu_reset ? 32'd0 : pc + 32'd4;
  end

  function automatic logic [66:0] ent(input logic [1:0] st, input logic rst,
                                      input logic [31:0] cnt, input logic [31:0] p);
    return {st, rst, cnt, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input int max_cyc);
    int n = 0;
    while (instr_count !== target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count", instr_count, target);
  endtask

  task automatic wait_state(input logic [1:0] target, input int max_cyc);
    int n = 0;
    while (state !== target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", {30'd0, state}, {30'd0, target});
  endtask

  // monitor / scoreboard
  initial begin
    logic [66:0] got, want;
    forever begin
      @(negedge clk);
      if (reset_n && cpu_ce === 1'b1) begin
        got = {state, cpu_reset, instr_count, pc};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_ce actual st=%0d rst=%0b cnt=%0d pc=0x%0h required=no pulse",
                   state, cpu_reset, instr_count, pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL sb_ce actual st=%0d rst=%0b cnt=%0d pc=0x%0h required st=%0d rst=%0b cnt=%0d pc=0x%0h",
                     got[66:65], got[64], got[63:32], got[31:0],
                     want[66:65], want[64], want[63:32], want[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // driver
  initial begin
    reset_n = 1'b1; run_sw = 1'b0; step_btn = 1'b0; rst_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0; pc_set = 1'b0; pc_set_val = 32'd0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {30'd0, state}, {30'd0, S_RESET});
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_instr_count", instr_count, 32'd0);
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);

    // 1: two reset enables, then HALT
    exp_q.push_back(ent(S_RESET, 1'b1, 32'd0, 32'd0));
    exp_q.push_back(ent(S_RESET, 1'b1, 32'd0, 32'd0));
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("s1_state", {30'd0, state}, {30'd0, S_HALT});
    chk("s1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("s1_halted", {31'd0, halted}, 32'd1);
    chk("s1_instr_count", instr_count, 32'd0);

    // 2: free run for 10 pulses, then drop run_sw
    for (int i = 0; i < 10; i++) exp_q.push_back(ent(S_RUN, 1'b0, 32'(i), 32'(4 * i)));
    run_sw = 1'b1;
    wait_count(32'd10, 100);
    run_sw = 1'b0;
    repeat (3) @(negedge clk);
    chk("s2_halt_state", {30'd0, state}, {30'd0, S_HALT});
    repeat (10) @(negedge clk);
    chk("s2_no_more_ce", instr_count, 32'd10);

    // 3: accepted step press, then a rejected glitch
    exp_q.push_back(ent(S_STEP, 1'b0, 32'd10, 32'h28));
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("s3_step_count", instr_count, 32'd11);
    chk("s3_state", {30'd0, state}, {30'd0, S_HALT});
    step_btn = 1'b1;
    repeat (2) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("s3_glitch_count", instr_count, 32'd11);

    // 4: breakpoint at 0x10
    pc_set = 1'b1; pc_set_val = 32'h08;
    @(negedge clk);
    pc_set = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10;
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd11, 32'h08));
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd12, 32'h0C));
    run_sw = 1'b1;
    wait_count(32'd13, 100);
    wait_state(S_HALT, 10);
    chk("s4_bp_hit", {31'd0, bp_hit}, 32'd1);
    chk("s4_halted", {31'd0, halted}, 32'd1);
    repeat (8) @(negedge clk);
    chk("s4_held_halt", {30'd0, state}, {30'd0, S_HALT});
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd13, 32'h10));
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd14, 32'h14));
    run_sw = 1'b0;
    repeat (4) @(negedge clk);
    run_sw = 1'b1;
    wait_count(32'd15, 100);
    chk("s4_bp_cleared", {31'd0, bp_hit}, 32'd0);
    chk("s4_running", {30'd0, state}, {30'd0, S_RUN});

    // 5: rst_btn held 20 cycles mid-run
    bp_en = 1'b0;
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd15, 32'h18));
    exp_q.push_back(ent(S_RESET, 1'b1, 32'd0, 32'h1C));
    for (int i = 0; i < 5; i++) exp_q.push_back(ent(S_RESET, 1'b1, 32'd0, 32'd0));
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd0, 32'd0));
    exp_q.push_back(ent(S_RUN, 1'b0, 32'd1, 32'd4));
    rst_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("s5_state", {30'd0, state}, {30'd0, S_RESET});
    chk("s5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("s5_instr_count", instr_count, 32'd0);
    repeat (10) @(negedge clk);
    chk("s5_held", {30'd0, state}, {30'd0, S_RESET});
    rst_btn = 1'b0;
    wait_count(32'd2, 100);
    chk("s5_run", {30'd0, state}, {30'd0, S_RUN});

    // 6: asynchronous reset during STEP
    run_sw = 1'b0;
    wait_state(S_HALT, 10);
    step_btn = 1'b1;
    begin
      int n = 0;
      @(posedge clk); #1;
      while (state !== S_STEP && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("s6_in_step", {30'd0, state}, {30'd0, S_STEP});
    reset_n = 1'b0;
    #1;
    chk("s6_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("s6_state", {30'd0, state}, {30'd0, S_RESET});
    chk("s6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("s6_halted", {31'd0, halted}, 32'd0);
    chk("s6_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("s6_instr_count", instr_count, 32'd0);
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
